alu_issue_ctrl: RTL and testbench

// Initiator side of the ALU interface: accepts a decoded MIPS instruction plus register operands,

---
 rtl/alu_issue_ctrl_if.sv | 36 +++
 rtl/alu_issue_ctrl.sv | 164 ++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_ctrl_if.sv
// Handshake, operand and ALU-side signal bundle for alu_issue_ctrl.
// master is the environment (register read, ALU, writeback); slave is the controller.
interface alu_issue_if;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [15:0] imm;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_control;
  logic [31:0] alu_res;
  logic        alu_zero;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_res;
  logic        out_taken;
  logic        out_illegal;

  modport master (
    output in_valid, opcode, funct, shamt, imm,
    output rs_val, rt_val, alu_res, alu_zero, out_ready,
    input  in_ready, alu_a, alu_b, alu_control,
    input  out_valid, out_res, out_taken, out_illegal
  );

  modport slave (
    input  in_valid, opcode, funct, shamt, imm,
    input  rs_val, rt_val, alu_res, alu_zero, out_ready,
    output in_ready, alu_a, alu_b, alu_control,
    output out_valid, out_res, out_taken, out_illegal
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: decodes MIPS opcode/funct, holds ALU operands
// for EXEC_CYCLES, then captures result and branch decision.
module alu_issue_ctrl #(
  parameter int unsigned EXEC_CYCLES = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_issue_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam int CW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(EXEC_CYCLES - 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   a_q, a_d, b_q, b_d;
  logic [3:0]    ctl_q, ctl_d;
  logic          br_q, br_d;
  logic          ill_q, ill_d;
  logic [31:0]   res_q, res_d;
  logic          tkn_q, tkn_d;
  logic          oill_q, oill_d;

  logic [31:0] dec_a, dec_b;
  logic [3:0]  dec_ctl;
  logic        dec_br, dec_ill;
  logic        rtyp;
  logic [31:0] sext, zsh;

  assign rtyp = (bus.opcode == 6'h00);
  assign sext = {{16{bus.imm[15]}}, bus.imm};
  assign zsh  = {27'd0, bus.shamt};

  always_comb begin
    dec_a   = bus.rs_val;
    dec_b   = bus.rt_val;
    dec_ctl = 4'b0000;
    dec_br  = 1'b0;
    dec_ill = 1'b0;
    unique case (1'b1)
      rtyp && bus.funct == 6'h20: dec_ctl = 4'b0000;
      rtyp && bus.funct == 6'h22: dec_ctl = 4'b0001;
      rtyp && bus.funct == 6'h18: dec_ctl = 4'b0010;
      rtyp && bus.funct == 6'h24: dec_ctl = 4'b0101;
      rtyp && bus.funct == 6'h26: dec_ctl = 4'b0110;
      rtyp && bus.funct == 6'h25: dec_ctl = 4'b0111;
      rtyp && bus.funct == 6'h27: dec_ctl = 4'b1000;
      rtyp && bus.funct == 6'h03: begin
        dec_ctl = 4'b0011;
        dec_a   = bus.rt_val;
        dec_b   = zsh;
      end
      rtyp && bus.funct == 6'h00: begin
        dec_ctl = 4'b0100;
        dec_a   = bus.rt_val;
        dec_b   = zsh;
      end
      bus.opcode == 6'h08: begin
        dec_ctl = 4'b1001;
        dec_b   = sext;
      end
      bus.opcode == 6'h23 || bus.opcode == 6'h2B: begin
        dec_ctl = 4'b1100;
        dec_b   = sext;
      end
      bus.opcode == 6'h04: begin
        dec_ctl = 4'b1011;
        dec_br  = 1'b1;
      end
      bus.opcode == 6'h05: begin
        dec_ctl = 4'b1010;
        dec_br  = 1'b1;
      end
      default: begin
        dec_a   = 32'd0;
        dec_b   = 32'd0;
        dec_ill = 1'b1;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    ctl_d   = ctl_q;
    br_d    = br_q;
    ill_d   = ill_q;
    res_d   = res_q;
    tkn_d   = tkn_q;
    oill_d  = oill_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = EXEC;
          cnt_d   = '0;
          a_d     = dec_a;
          b_d     = dec_b;
          ctl_d   = dec_ctl;
          br_d    = dec_br;
          ill_d   = dec_ill;
          res_d   = 32'd0;
          tkn_d   = 1'b0;
          oill_d  = 1'b0;
        end
      end
      EXEC: begin
        if (cnt_q == LAST) begin
          state_d = DONE;
          cnt_d   = '0;
          res_d   = (br_q || ill_q) ? 32'd0 : bus.alu_res;
          tkn_d   = br_q & bus.alu_zero;
          oill_d  = ill_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      ctl_q   <= 4'd0;
      br_q    <= 1'b0;
      ill_q   <= 1'b0;
      res_q   <= 32'd0;
      tkn_q   <= 1'b0;
      oill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ctl_q   <= ctl_d;
      br_q    <= br_d;
      ill_q   <= ill_d;
      res_q   <= res_d;
      tkn_q   <= tkn_d;
      oill_q  <= oill_d;
    end
  end

  assign bus.in_ready    = (state_q == IDLE);
  assign bus.out_valid   = (state_q == DONE);
  assign bus.alu_a       = a_q;
  assign bus.alu_b       = b_q;
  assign bus.alu_control = ctl_q;
  assign bus.out_res     = res_q;
  assign bus.out_taken   = tkn_q;
  assign bus.out_illegal = oill_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with a behavioural ALU,
// one instance at EXEC_CYCLES=1 and one at EXEC_CYCLES=4.
module tb_alu_issue_ctrl;

  typedef struct packed {
    logic [31:0] res;
    logic        tk;
    logic        il;
    logic [3:0]  ctl;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [5:0]  op = '0, fn = '0;
  logic [4:0]  sh = '0;
  logic [15:0] im = '0;
  logic [31:0] rs = '0, rt = '0;
  logic        v1 = 1'b0, v4 = 1'b0, ordy = 1'b1;
  logic        sel = 1'b0;

  alu_issue_if b1();
  alu_issue_if b4();

  alu_issue_ctrl #(.EXEC_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(b1)
  );
  alu_issue_ctrl #(.EXEC_CYCLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(b4)
  );

  function automatic logic [32:0] alu_f(
    input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic z;
    case (c)
      4'h0, 4'h9, 4'hC: r = a + b;
      4'h1, 4'hA, 4'hB: r = a - b;
      4'h2: r = a * b;
      4'h3: r = $signed(a) >>> b[4:0];
      4'h4: r = a << b[4:0];
      4'h5: r = a & b;
      4'h6: r = a ^ b;
      4'h7: r = a | b;
      4'h8: r = ~(a | b);
      default: r = 32'd0;
    endcase
    z = (c == 4'hA) ? (a != b) : (r == 32'd0);
    return {z, r};
  endfunction

  assign b1.opcode = op;  assign b4.opcode = op;
  assign b1.funct  = fn;  assign b4.funct  = fn;
  assign b1.shamt  = sh;  assign b4.shamt  = sh;
  assign b1.imm    = im;  assign b4.imm    = im;
  assign b1.rs_val = rs;  assign b4.rs_val = rs;
  assign b1.rt_val = rt;  assign b4.rt_val = rt;
  assign b1.in_valid  = v1;
  assign b4.in_valid  = v4;
  assign b1.out_ready = ordy;
  assign b4.out_ready = ordy;
  assign {b1.alu_zero, b1.alu_res} = alu_f(b1.alu_control, b1.alu_a, b1.alu_b);
  assign {b4.alu_zero, b4.alu_res} = alu_f(b4.alu_control, b4.alu_a, b4.alu_b);

  logic        ov, ir, otk, oil;
  logic [31:0] ores, aa, ab;
  logic [3:0]  actl;
  always_comb begin
    ov   = sel ? b4.out_valid   : b1.out_valid;
    ir   = sel ? b4.in_ready    : b1.in_ready;
    otk  = sel ? b4.out_taken   : b1.out_taken;
    oil  = sel ? b4.out_illegal : b1.out_illegal;
    ores = sel ? b4.out_res     : b1.out_res;
    aa   = sel ? b4.alu_a       : b1.alu_a;
    ab   = sel ? b4.alu_b       : b1.alu_b;
    actl = sel ? b4.alu_control : b1.alu_control;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;
  exp_t sbq[$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic exp_t ref_f(
    input logic [5:0] o, input logic [5:0] f, input logic [4:0] h,
    input logic [15:0] i, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [31:0] sx;
    sx = {{16{i[15]}}, i};
    e = '0;
    e.a = a;
    e.b = b;
    if (o == 6'h00) begin
      case (f)
        6'h20: begin e.ctl = 4'b0000; e.res = a + b; end
        6'h22: begin e.ctl = 4'b0001; e.res = a - b; end
        6'h18: begin e.ctl = 4'b0010; e.res = a * b; end
        6'h24: begin e.ctl = 4'b0101; e.res = a & b; end
        6'h26: begin e.ctl = 4'b0110; e.res = a ^ b; end
        6'h25: begin e.ctl = 4'b0111; e.res = a | b; end
        6'h27: begin e.ctl = 4'b1000; e.res = ~(a | b); end
        6'h03: begin
          e.ctl = 4'b0011; e.a = b; e.b = {27'd0, h};
          e.res = $signed(b) >>> h;
        end
        6'h00: begin
          e.ctl = 4'b0100; e.a = b; e.b = {27'd0, h};
          e.res = b << h;
        end
        default: e.il = 1'b1;
      endcase
    end else begin
      case (o)
        6'h08, 6'h23, 6'h2B: begin
          e.ctl = (o == 6'h08) ? 4'b1001 : 4'b1100;
          e.b = sx;
          e.res = a + sx;
        end
        6'h04: begin e.ctl = 4'b1011; e.tk = (a == b); end
        6'h05: begin e.ctl = 4'b1010; e.tk = (a != b); end
        default: e.il = 1'b1;
      endcase
    end
    if (e.il) begin
      e.a = '0; e.b = '0; e.ctl = '0; e.res = '0;
    end
    return e;
  endfunction

  task automatic issue(input bit s, input logic [5:0] o, input logic [5:0] f,
                       input logic [4:0] h, input logic [15:0] i,
                       input logic [31:0] a, input logic [31:0] b,
                       output int acc);
    exp_t e;
    int n;
    sel = s;
    @(negedge clk);
    op = o; fn = f; sh = h; im = i; rs = a; rt = b;
    n = 0;
    while (!ir && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_before_issue", ir, 1);
    if (s) v4 = 1'b1;
    else v1 = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    v1 = 1'b0;
    v4 = 1'b0;
    e = ref_f(o, f, h, i, a, b);
    chk("alu_a", aa, e.a);
    chk("alu_b", ab, e.b);
    chk("alu_control", actl, e.ctl);
    chk("in_ready_busy", ir, 0);
    sbq.push_back(e);
  endtask

  task automatic collect(input int lat, input int acc, input int hold);
    exp_t e;
    int n;
    n = 0;
    @(negedge clk);
    while (!ov && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("out_valid", ov, 1);
    chk("latency", cyc - acc, lat);
    chk("sb_nonempty", sbq.size() > 0, 1);
    e = (sbq.size() > 0) ? sbq.pop_front() : '0;
    chk("out_res", ores, e.res);
    chk("out_taken", otk, e.tk);
    chk("out_illegal", oil, e.il);
    for (int k = 0; k < hold; k++) begin
      op = 6'h08; rs = 32'h55; im = 16'h1;
      if (sel) v4 = 1'b1;
      else v1 = 1'b1;
      @(negedge clk);
      chk("hold_valid", ov, 1);
      chk("hold_res", ores, e.res);
      chk("hold_taken", otk, e.tk);
      chk("hold_in_ready", ir, 0);
    end
    v1 = 1'b0;
    v4 = 1'b0;
    ordy = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", ir, 1);
    chk("idle_out_valid", ov, 0);
  endtask

  initial begin
    int acc;
    int seen;
    #2;
    sel = 1'b0;
    #0;
    chk("rst_in_ready", b1.in_ready, 1);
    chk("rst_out_valid", b1.out_valid, 0);
    chk("rst_alu_a", b1.alu_a, 0);
    chk("rst_alu_ctl", b1.alu_control, 0);
    chk("rst_out_res", b1.out_res, 0);
    chk("rst4_in_ready", b4.in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    issue(0, 6'h00, 6'h20, 5'd0, 16'h0, 32'd5, 32'd7, acc);
    collect(1, acc, 0);
    issue(0, 6'h04, 6'h00, 5'd0, 16'h0, 32'h1234, 32'h1234, acc);
    collect(1, acc, 0);
    issue(0, 6'h05, 6'h00, 5'd0, 16'h0, 32'h1234, 32'h1234, acc);
    collect(1, acc, 0);
    issue(0, 6'h05, 6'h00, 5'd0, 16'h0, 32'h1234, 32'h1235, acc);
    collect(1, acc, 0);
    issue(0, 6'h08, 6'h00, 5'd0, 16'hFFFF, 32'd10, 32'd0, acc);
    collect(1, acc, 0);
    issue(0, 6'h00, 6'h00, 5'd4, 16'h0, 32'd99, 32'd1, acc);
    collect(1, acc, 0);
    issue(0, 6'h00, 6'h03, 5'd4, 16'h0, 32'd0, 32'h80000000, acc);
    collect(1, acc, 0);
    issue(0, 6'h00, 6'h22, 5'd0, 16'h0, 32'd3, 32'd5, acc);
    collect(1, acc, 0);
    issue(0, 6'h00, 6'h27, 5'd0, 16'h0, 32'h0F0F0000, 32'h000000F0, acc);
    collect(1, acc, 0);
    issue(0, 6'h23, 6'h00, 5'd0, 16'h8000, 32'h00010000, 32'd0, acc);
    collect(1, acc, 0);

    ordy = 1'b0;
    issue(0, 6'h00, 6'h24, 5'd0, 16'h0, 32'hF0F0F0F0, 32'hFF00FF00, acc);
    collect(1, acc, 5);

    issue(0, 6'h3F, 6'h20, 5'd0, 16'h0, 32'd8, 32'd9, acc);
    collect(1, acc, 0);
    issue(0, 6'h00, 6'h3F, 5'd0, 16'h0, 32'd8, 32'd9, acc);
    collect(1, acc, 0);

    issue(1, 6'h00, 6'h18, 5'd0, 16'h0, 32'd3, 32'h80000001, acc);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("mult_hold_a", aa, 32'd3);
      chk("mult_hold_b", ab, 32'h80000001);
      chk("mult_hold_ctl", actl, 4'b0010);
      chk("mult_not_valid", ov, 0);
    end
    collect(4, acc, 0);

    issue(1, 6'h00, 6'h20, 5'd0, 16'h0, 32'd1, 32'd2, acc);
    void'(sbq.pop_back());
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", ir, 1);
    chk("midrst_out_valid", ov, 0);
    chk("midrst_alu_a", aa, 0);
    chk("midrst_alu_b", ab, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (ov) seen++;
    end
    chk("midrst_no_valid", seen, 0);
    chk("midrst_idle", ir, 1);
    chk("sb_drained", sbq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
